// File: rtl/mul_pipe_unit.sv
// Pipelined mullw/mulli/mulhw/mulhwu unit: STAGES-deep, one op/cycle, in-order completion tagged by RS id.
// Latency STAGES cycles; per-stage ready collapses bubbles under output backpressure; flush kills all stages.
module mul_pipe_unit #(
  parameter int RS_ID_WIDTH = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int STAGES      = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   input_valid,
  output logic                   input_ready,
  input  logic [RS_ID_WIDTH-1:0] rs_id_in,
  input  logic [4:0]             result_reg_addr_in,
  input  logic [DATA_WIDTH-1:0]  op1,
  input  logic [DATA_WIDTH-1:0]  op2,
  input  logic                   xer_so_in,
  input  logic                   mul_high,
  input  logic                   mul_signed,
  input  logic                   oe,
  input  logic                   rc,
  input  logic                   flush,
  output logic                   output_valid,
  input  logic                   output_ready,
  output logic [RS_ID_WIDTH-1:0] rs_id_out,
  output logic [4:0]             result_reg_addr_out,
  output logic [DATA_WIDTH-1:0]  result,
  output logic                   ov,
  output logic                   so,
  output logic                   oe_out,
  output logic [3:0]             cr0,
  output logic                   rc_out,
  output logic                   busy
);
  localparam int PW = 2 * DATA_WIDTH;

  typedef struct packed {
    logic [RS_ID_WIDTH-1:0] rs_id;
    logic [4:0]             addr;
    logic [DATA_WIDTH-1:0]  result;
    logic                   ov;
    logic                   so;
    logic                   oe;
    logic [3:0]             cr0;
    logic                   rc;
  } payload_t;

  logic [STAGES-1:0]   vld_q, vld_d, rdy, src_vld;
  payload_t            stg_q   [STAGES];
  payload_t            stg_d   [STAGES];
  payload_t            src_pay [STAGES];
  payload_t            in_pay;
  payload_t            out_pay;
  logic [PW-1:0]       ext1, ext2, prod;
  logic [DATA_WIDTH:0] top_bits;

  // The whole result is formed before stage 0; later stages only carry it.
  always_comb begin
    ext1     = {{DATA_WIDTH{mul_signed & op1[DATA_WIDTH-1]}}, op1};
    ext2     = {{DATA_WIDTH{mul_signed & op2[DATA_WIDTH-1]}}, op2};
    prod     = ext1 * ext2;
    top_bits = prod[PW-1:DATA_WIDTH-1];
    in_pay        = '0;
    in_pay.rs_id  = rs_id_in;
    in_pay.addr   = result_reg_addr_in;
    in_pay.result = mul_high ? prod[PW-1:DATA_WIDTH] : prod[DATA_WIDTH-1:0];
    in_pay.ov     = oe & ~mul_high & ~((&top_bits) | ~(|top_bits));
    in_pay.so     = xer_so_in | in_pay.ov;
    in_pay.oe     = oe;
    in_pay.rc     = rc;
    in_pay.cr0    = {in_pay.result[DATA_WIDTH-1],
                     ~in_pay.result[DATA_WIDTH-1] & (|in_pay.result),
                     ~(|in_pay.result),
                     in_pay.so};
  end

  // Stage i can load when any stage at or after it is empty, or the consumer drains.
  always_comb begin
    rdy = '0;
    for (int i = 0; i < STAGES; i++) begin
      rdy[i] = output_ready;
      for (int j = i; j < STAGES; j++) begin
        rdy[i] = rdy[i] | ~vld_q[j];
      end
    end
  end

  always_comb begin
    src_vld    = '0;
    src_vld[0] = input_valid;
    src_pay[0] = in_pay;
    for (int i = 1; i < STAGES; i++) begin
      src_vld[i] = vld_q[i-1];
      src_pay[i] = stg_q[i-1];
    end
  end

  always_comb begin
    vld_d = vld_q;
    for (int i = 0; i < STAGES; i++) begin
      stg_d[i] = stg_q[i];
      if (rdy[i]) begin
        vld_d[i] = src_vld[i];
        if (src_vld[i]) stg_d[i] = src_pay[i];
      end
    end
    if (flush) vld_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < STAGES; i++) stg_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < STAGES; i++) stg_q[i] <= stg_d[i];
    end
  end

  assign out_pay             = stg_q[STAGES-1];
  assign input_ready         = rdy[0];
  assign output_valid        = vld_q[STAGES-1];
  assign rs_id_out           = out_pay.rs_id;
  assign result_reg_addr_out = out_pay.addr;
  assign result              = out_pay.result;
  assign ov                  = out_pay.ov;
  assign so                  = out_pay.so;
  assign oe_out              = out_pay.oe;
  assign cr0                 = out_pay.cr0;
  assign rc_out              = out_pay.rc;
  assign busy                = |vld_q;

  stall_stable_a: assert property (@(posedge clk) disable iff (!rst)
    (output_valid && !output_ready) |=> $stable(out_pay));
  stages_range_a: assert property (@(posedge clk) (STAGES >= 1) && (STAGES <= 8));
endmodule

// File: tb/tb_mul_pipe_unit.sv
// Directed bench for mul_pipe_unit (STAGES=3, 32-bit) with a queue scoreboard fed at input handshake.
module tb_mul_pipe_unit;
  localparam int RSW = 5;
  localparam int DW  = 32;
  localparam int ST  = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           input_valid, input_ready;
  logic [RSW-1:0] rs_id_in, rs_id_out;
  logic [4:0]     result_reg_addr_in, result_reg_addr_out;
  logic [DW-1:0]  op1, op2, result;
  logic           xer_so_in, mul_high, mul_signed, oe, rc, flush;
  logic           output_valid, output_ready;
  logic           ov, so, oe_out, rc_out, busy;
  logic [3:0]     cr0;

  always #5 clk = ~clk;

  mul_pipe_unit #(.RS_ID_WIDTH(RSW), .DATA_WIDTH(DW), .STAGES(ST)) dut (
    .clk(clk), .rst(rst),
    .input_valid(input_valid), .input_ready(input_ready),
    .rs_id_in(rs_id_in), .result_reg_addr_in(result_reg_addr_in),
    .op1(op1), .op2(op2), .xer_so_in(xer_so_in),
    .mul_high(mul_high), .mul_signed(mul_signed), .oe(oe), .rc(rc), .flush(flush),
    .output_valid(output_valid), .output_ready(output_ready),
    .rs_id_out(rs_id_out), .result_reg_addr_out(result_reg_addr_out),
    .result(result), .ov(ov), .so(so), .oe_out(oe_out),
    .cr0(cr0), .rc_out(rc_out), .busy(busy)
  );

  typedef struct packed {
    logic [RSW-1:0] id;
    logic [4:0]     addr;
    logic [DW-1:0]  res;
    logic           ov;
    logic           so;
    logic           oe;
    logic           rc;
    logic [3:0]     cr0;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            failures = 0;
  int            out_cnt = 0;
  int            acc_cnt = 0;
  int            streak = 0;
  int            max_streak = 0;
  logic          prev_out = 1'b0;
  int            blk_base = 0;
  int            blk_at = -1;
  logic          stall_prev = 1'b0;
  logic [RSW-1:0] stall_id;
  logic [DW-1:0] stall_res;
  logic [3:0]    stall_cr0;
  logic [DW-1:0] last_res;
  logic [3:0]    last_cr0;
  logic          last_ov, last_so;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: full-width 64-bit product by plain signed/unsigned arithmetic.
  function automatic exp_t model(input logic [RSW-1:0] id, input logic [4:0] addr,
                                 input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic so_in, input logic hi, input logic sg,
                                 input logic oe_i, input logic rc_i);
    exp_t        e;
    longint      sa, sbv;
    logic [63:0] p;
    logic [32:0] top;
    if (sg) begin
      sa  = $signed(a);
      sbv = $signed(b);
      p   = sa * sbv;
    end else begin
      p = {32'h0, a} * {32'h0, b};
    end
    top    = p[63:31];
    e.id   = id;
    e.addr = addr;
    e.res  = hi ? p[63:32] : p[31:0];
    e.ov   = oe_i && !hi && !(top == 33'h0 || top == {33{1'b1}});
    e.so   = so_in || e.ov;
    e.oe   = oe_i;
    e.rc   = rc_i;
    e.cr0  = {($signed(e.res) < 0), ($signed(e.res) > 0), (e.res == 0), e.so};
    return e;
  endfunction

  // Samples both handshakes mid-cycle, then advances to just after the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (stall_prev && output_valid) begin
      check("stall_id", rs_id_out, stall_id);
      check("stall_res", result, stall_res);
      check("stall_cr0", cr0, stall_cr0);
    end
    if (output_valid && output_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        e = sb.pop_front();
        check("out_id", rs_id_out, e.id);
        check("out_addr", result_reg_addr_out, e.addr);
        check("out_res", result, e.res);
        check("out_ov", ov, e.ov);
        check("out_so", so, e.so);
        check("out_oe", oe_out, e.oe);
        check("out_rc", rc_out, e.rc);
        check("out_cr0", cr0, e.cr0);
      end
      last_res = result; last_cr0 = cr0; last_ov = ov; last_so = so;
      out_cnt++;
      streak = prev_out ? streak + 1 : 1;
      if (streak > max_streak) max_streak = streak;
      prev_out = 1'b1;
    end else begin
      prev_out = 1'b0;
    end
    if (input_valid && !input_ready && blk_at < 0) blk_at = acc_cnt - blk_base;
    if (input_valid && input_ready) begin
      acc_cnt++;
      if (!flush) sb.push_back(model(rs_id_in, result_reg_addr_in, op1, op2, xer_so_in,
                                     mul_high, mul_signed, oe, rc));
    end
    if (flush) sb.delete();
    stall_prev = output_valid && !output_ready && !flush;
    stall_id = rs_id_out; stall_res = result; stall_cr0 = cr0;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [RSW-1:0] id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic hi, input logic sg, input logic oe_i, input logic rc_i,
                        input logic so_in);
    input_valid = 1'b1; rs_id_in = id; result_reg_addr_in = 5'(id + 3);
    op1 = a; op2 = b; mul_high = hi; mul_signed = sg; oe = oe_i; rc = rc_i; xer_so_in = so_in;
  endtask

  task automatic idle();
    input_valid = 1'b0;
  endtask

  task automatic expect_latency(input string tag, input int exp_lat);
    int k;
    int base;
    base = out_cnt;
    k = 0;
    while (out_cnt == base && k < 20) begin
      tick();
      k++;
    end
    check(tag, k, exp_lat);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() > 0 && k < 40) begin
      tick();
      k++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int base;
    rst = 1'b0; input_valid = 1'b0; rs_id_in = '0; result_reg_addr_in = '0;
    op1 = '0; op2 = '0; xer_so_in = 1'b0; mul_high = 1'b0; mul_signed = 1'b0;
    oe = 1'b0; rc = 1'b0; flush = 1'b0; output_ready = 1'b1;
    #2;
    check("rst_out_valid", output_valid, 0);
    check("rst_in_ready", input_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_payload", {rs_id_out, result_reg_addr_out, result, ov, so, oe_out, cr0, rc_out}, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // mullw overflow into the high word
    set_op(5'd1, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(); idle();
    expect_latency("t1_latency", ST);
    check("t1_res", last_res, 32'h0);
    check("t1_ov", last_ov, 1);
    check("t1_so", last_so, 1);
    check("t1_cr0", last_cr0, 4'b0011);

    // mulhw / mulhwu of -1 (or 2^32-1) by 2
    set_op(5'd2, 32'hFFFF_FFFF, 32'h2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(); idle();
    expect_latency("t2s_latency", ST);
    check("t2s_res", last_res, 32'hFFFF_FFFF);
    check("t2s_cr0", last_cr0, 4'b1000);
    set_op(5'd3, 32'hFFFF_FFFF, 32'h2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); idle();
    expect_latency("t2u_latency", ST);
    check("t2u_res", last_res, 32'h1);
    check("t2u_cr0", last_cr0, 4'b0100);

    // back-to-back stream
    base = out_cnt; max_streak = 0;
    for (int i = 0; i < 8; i++) begin
      set_op(5'(i), 32'h1234_5678 * (i + 1), 32'hFFFF_FFF0 + i, 1'(i % 2), 1'(i / 4), 1'b1, 1'b1, 1'(i == 5));
      check("t3_in_ready", input_ready, 1);
      tick();
    end
    idle();
    drain();
    check("t3_count", out_cnt - base, 8);
    check("t3_streak", max_streak, 8);

    // output backpressure fills the pipe
    base = out_cnt; output_ready = 1'b0; blk_base = acc_cnt; blk_at = -1;
    for (int k = 0; k < 40 && ((acc_cnt - blk_base) < 5 || sb.size() > 0); k++) begin
      if ((acc_cnt - blk_base) < 5)
        set_op(5'(10 + acc_cnt - blk_base), 32'h8000_0001 + k, 32'h7FFF_FFF3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      else
        idle();
      if (k == 8) output_ready = 1'b1;
      tick();
    end
    idle();
    check("t4_block_after", blk_at, 3);
    check("t4_count", out_cnt - base, 5);

    // flush two in flight plus one accepted in the flush cycle
    output_ready = 1'b1;
    set_op(5'd20, 32'd7, 32'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    set_op(5'd21, 32'd5, 32'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    set_op(5'd22, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); flush = 1'b1; tick();
    flush = 1'b0; idle();
    check("t5_busy", busy, 0);
    check("t5_in_ready", input_ready, 1);
    check("t5_out_valid", output_valid, 0);
    base = out_cnt;
    repeat (6) tick();
    check("t5_no_output", out_cnt - base, 0);

    // flush coinciding with an output handshake still delivers that result
    base = out_cnt;
    set_op(5'd23, 32'd11, 32'd13, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick(); idle();
    tick(); tick();
    flush = 1'b1; tick(); flush = 1'b0;
    check("t5b_delivered", out_cnt - base, 1);
    check("t5b_busy", busy, 0);

    // async reset while stalled
    output_ready = 1'b0;
    set_op(5'd24, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    set_op(5'd25, 32'd4, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    idle();
    check("t6_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    check("t6_out_valid", output_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_in_ready", input_ready, 1);
    sb.delete(); stall_prev = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; output_ready = 1'b1;
    set_op(5'd26, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(); idle();
    expect_latency("t6_latency", ST);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
